// File: rtl/synth_pkg.sv
// Shared types and widths for the FM voice allocator.
// Contents: voice state enum, controller state enum, default note/phaseinc
// widths, release and age counter widths.
package synth_pkg;
    localparam int NOTE_W_DEF = 7;
    localparam int PINC_W_DEF = 16;
    localparam int REL_W      = 32;
    localparam int AGE_W      = 16;

    typedef enum logic [1:0] {
        V_IDLE    = 2'd0,
        V_HELD    = 2'd1,
        V_RELEASE = 2'd2
    } voice_state_e;

    typedef enum logic {
        C_ACCEPT = 1'b0,
        C_UPDATE = 1'b1
    } ctrl_state_e;
endpackage

// File: rtl/voice_slot.sv
// One operator voice: voice FSM, release countdown, age counter, stored
// note/phaseinc and trig generation with the one-cycle retrigger gap.
// Optional feature macro: VOICE_STEAL_EN (adds the age counter and port).
// Ports:
//   clk24, rst      clock, synchronous active-high reset
//   note_on         commit a note-on to this voice (alloc, retrigger or steal)
//   note_off        commit a note-off to this voice (only acted on in HELD)
//   on_note/on_pinc note number and phase increment for note_on
//   rel_time        release duration, loaded on HELD->RELEASE
//   state, note     current voice state and stored note
//   phaseinc, trig  operator drive
//   age             cycles since last note_on, saturating (steal builds only)
module voice_slot
    import synth_pkg::*;
#(
    parameter int NOTE_W = NOTE_W_DEF,
    parameter int PINC_W = PINC_W_DEF
) (
    input  logic              clk24,
    input  logic              rst,
    input  logic              note_on,
    input  logic              note_off,
    input  logic [NOTE_W-1:0] on_note,
    input  logic [PINC_W-1:0] on_pinc,
    input  logic [REL_W-1:0]  rel_time,
    output voice_state_e      state,
    output logic [NOTE_W-1:0] note,
    output logic [PINC_W-1:0] phaseinc,
    output logic              trig
`ifdef VOICE_STEAL_EN
    ,
    output logic [AGE_W-1:0]  age
`endif
);
    logic             gap;
    logic [REL_W-1:0] rel_cnt;

    always_ff @(posedge clk24) begin
        if (rst) begin
            state    <= V_IDLE;
            note     <= '0;
            phaseinc <= '0;
            trig     <= 1'b0;
            gap      <= 1'b0;
            rel_cnt  <= '0;
        end else begin
            gap <= 1'b0;
            if (note_on) begin
                note     <= on_note;
                phaseinc <= on_pinc;
                state    <= V_HELD;
                // A busy voice gets a one-cycle low on trig so the operator
                // sees a fresh edge; an idle voice goes high immediately.
                trig     <= (state == V_IDLE);
                gap      <= (state != V_IDLE);
            end else if (note_off && state == V_HELD) begin
                state   <= V_RELEASE;
                rel_cnt <= rel_time;
                trig    <= 1'b0;
            end else if (state == V_RELEASE) begin
                if (rel_cnt == '0) state <= V_IDLE;
                else               rel_cnt <= rel_cnt - 1'b1;
            end else if (gap) begin
                trig <= 1'b1;
            end
        end
    end

`ifdef VOICE_STEAL_EN
    always_ff @(posedge clk24) begin
        if (rst || note_on)                     age <= '0;
        else if (state != V_IDLE && age != '1) age <= age + 1'b1;
    end
`endif
endmodule

// File: rtl/voice_alloc.sv
// Voice allocator/sequencer for the FM operator bank.
// Two-state controller (ACCEPT/UPDATE): events are registered on accept and
// committed to one voice at the end of the following cycle.
// Optional feature macro: VOICE_STEAL_EN (steal oldest voice when full;
// otherwise full note-ons are dropped).
// Ports:
//   clk24, rst                     clock, synchronous active-high reset
//   ev_valid/ev_ready              event handshake
//   ev_on, ev_note, ev_phaseinc    event payload
//   rel_time                       release duration in cycles
//   voice_trig, voice_phaseinc     per-voice operator drive
//   voice_busy                     per-voice not-IDLE
//   drop, steal                    one-cycle pulses after UPDATE
module voice_alloc
    import synth_pkg::*;
#(
    parameter int NVOICES = 4,
    parameter int NOTE_W  = NOTE_W_DEF,
    parameter int PINC_W  = PINC_W_DEF
) (
    input  logic                      clk24,
    input  logic                      rst,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic                      ev_on,
    input  logic [NOTE_W-1:0]         ev_note,
    input  logic [PINC_W-1:0]         ev_phaseinc,
    input  logic [REL_W-1:0]          rel_time,
    output logic [NVOICES-1:0]        voice_trig,
    output logic [NVOICES*PINC_W-1:0] voice_phaseinc,
    output logic [NVOICES-1:0]        voice_busy,
    output logic                      drop,
    output logic                      steal
);
    localparam int IDX_W = $clog2(NVOICES);

    ctrl_state_e       ctrl;
    logic              ready;
    logic              on_q;
    logic [NOTE_W-1:0] note_q;
    logic [PINC_W-1:0] pinc_q;

    voice_state_e      vstate [NVOICES];
    logic [NOTE_W-1:0] vnote  [NVOICES];
    logic [NVOICES-1:0] cmd_on, cmd_off;
    logic              drop_n, steal_n;
    logic              match_any, idle_any;
    logic [IDX_W-1:0]  match_idx, idle_idx;

    assign ev_ready = ready;

    // ready is registered so it stays low through reset and rises one cycle
    // after reset is released.
    always_ff @(posedge clk24) begin
        if (rst) begin
            ctrl   <= C_ACCEPT;
            ready  <= 1'b0;
            on_q   <= 1'b0;
            note_q <= '0;
            pinc_q <= '0;
        end else begin
            case (ctrl)
                C_ACCEPT: begin
                    if (ev_valid && ready) begin
                        on_q   <= ev_on;
                        note_q <= ev_note;
                        pinc_q <= ev_phaseinc;
                        ctrl   <= C_UPDATE;
                        ready  <= 1'b0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                default: begin
                    ctrl  <= C_ACCEPT;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Lowest-index HELD voice with a matching note, and lowest-index IDLE
    // voice. Scanning downward leaves the lowest hit in the result.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        idle_any  = 1'b0;
        idle_idx  = '0;
        for (int i = NVOICES - 1; i >= 0; i--) begin
            if (vstate[i] == V_HELD && vnote[i] == note_q) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (vstate[i] == V_IDLE) begin
                idle_any = 1'b1;
                idle_idx = IDX_W'(i);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [AGE_W-1:0] vage [NVOICES];
    logic             rel_any;
    logic [IDX_W-1:0] rel_idx, held_idx, victim;
    logic [AGE_W-1:0] rel_age, held_age;

    // Oldest RELEASE voice first, else oldest HELD; strict compare keeps
    // the lowest index on ties.
    always_comb begin
        rel_any  = 1'b0;
        rel_idx  = '0;
        rel_age  = '0;
        held_idx = '0;
        held_age = '0;
        for (int i = 0; i < NVOICES; i++) begin
            if (vstate[i] == V_RELEASE && (!rel_any || vage[i] > rel_age)) begin
                rel_any = 1'b1;
                rel_idx = IDX_W'(i);
                rel_age = vage[i];
            end
            if (vstate[i] == V_HELD && (i == 0 || vage[i] > held_age)) begin
                held_idx = IDX_W'(i);
                held_age = vage[i];
            end
        end
        victim = rel_any ? rel_idx : held_idx;
    end
`endif

    always_comb begin
        cmd_on  = '0;
        cmd_off = '0;
        drop_n  = 1'b0;
        steal_n = 1'b0;
        if (ctrl == C_UPDATE) begin
            if (on_q) begin
                if (match_any)     cmd_on[match_idx] = 1'b1;
                else if (idle_any) cmd_on[idle_idx]  = 1'b1;
                else begin
`ifdef VOICE_STEAL_EN
                    cmd_on[victim] = 1'b1;
                    steal_n        = 1'b1;
`else
                    drop_n = 1'b1;
`endif
                end
            end else if (match_any) begin
                cmd_off[match_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk24) begin
        if (rst) drop <= 1'b0;
        else     drop <= drop_n;
    end

`ifdef VOICE_STEAL_EN
    always_ff @(posedge clk24) begin
        if (rst) steal <= 1'b0;
        else     steal <= steal_n;
    end
`else
    assign steal = 1'b0;
`endif

    for (genvar i = 0; i < NVOICES; i++) begin : g_voice
        voice_slot #(.NOTE_W(NOTE_W), .PINC_W(PINC_W)) u_slot (
            .clk24    (clk24),
            .rst      (rst),
            .note_on  (cmd_on[i]),
            .note_off (cmd_off[i]),
            .on_note  (note_q),
            .on_pinc  (pinc_q),
            .rel_time (rel_time),
            .state    (vstate[i]),
            .note     (vnote[i]),
            .phaseinc (voice_phaseinc[i*PINC_W +: PINC_W]),
            .trig     (voice_trig[i])
`ifdef VOICE_STEAL_EN
            ,
            .age      (vage[i])
`endif
        );
        assign voice_busy[i] = (vstate[i] != V_IDLE);
    end
endmodule
